vscale_dmem_slave: RTL and testbench

VSCALE_DMEM_SLAVE -- requirements
Module: vscale_dmem_slave

---
 rtl/vscale_dmem_slave.sv | 138 +++++++++++++
 tb/tb_vscale_dmem_slave.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_dmem_slave.sv
// AHB-Lite (HASTI) data-memory slave: byte/half/word access, optional wait states,
// two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
module vscale_dmem_slave #(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned HASTI_ADDR_WIDTH  = 32,
  localparam int unsigned HASTI_BUS_WIDTH   = 32,
  localparam int unsigned HASTI_SIZE_WIDTH  = 3,
  localparam int unsigned HASTI_TRANS_WIDTH = 2,
  localparam int unsigned HASTI_RESP_WIDTH  = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [HASTI_ADDR_WIDTH-1:0]  haddr,
  input  logic                         hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  hsize,
  input  logic [2:0]                   hburst,
  input  logic                         hmastlock,
  input  logic [3:0]                   hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0] htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   hrdata,
  output logic                         hready,
  output logic [HASTI_RESP_WIDTH-1:0]  hresp
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [HASTI_ADDR_WIDTH:0] ADDR_LIMIT = (HASTI_ADDR_WIDTH+1)'(DEPTH_WORDS) * (HASTI_ADDR_WIDTH+1)'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [7:0]                   r_wait_cnt;
  logic [7:0]                   w_wait_cnt_nxt;
  logic [IDX_W-1:0]             r_idx;
  logic [1:0]                   r_lane;
  logic [1:0]                   r_size;
  logic                         r_hwrite;
  logic [HASTI_BUS_WIDTH-1:0]   r_mem [DEPTH_WORDS];
  logic                         w_accept;
  logic                         w_bad;
  logic [3:0]                   w_be;
  logic                         w_unused;

  // Attributes the slave accepts but has no use for.
  assign w_unused = ^{htrans[0], hburst, hmastlock, hprot};

  assign w_bad = ({1'b0, haddr} >= ADDR_LIMIT)
              || (hsize > 3'd2)
              || ((hsize == 3'd1) && haddr[0])
              || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));

  // State register, wait counter and data-phase copy of the address phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 8'd0;
      r_idx      <= '0;
      r_lane     <= 2'd0;
      r_size     <= 2'd0;
      r_hwrite   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_accept) begin
        r_idx    <= haddr[IDX_W+1:2];
        r_lane   <= haddr[1:0];
        r_size   <= hsize[1:0];
        r_hwrite <= hwrite;
      end
    end
  end

  // Moore outputs and next-state logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    hready         = 1'b1;
    hresp          = 1'b0;
    hrdata         = '0;
    case (r_state)
      S_WAIT: hready = 1'b0;
      S_ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      S_ERR2: hresp = 1'b1;
      S_DATA: if (!r_hwrite) hrdata = r_mem[r_idx];
      default: ;
    endcase
    w_accept = hready && htrans[1];
    case (r_state)
      S_WAIT: begin
        w_wait_cnt_nxt = r_wait_cnt - 8'd1;
        if (r_wait_cnt == 8'd1) w_state_nxt = S_DATA;
      end
      S_ERR1: w_state_nxt = S_ERR2;
      default: begin
        if (!w_accept) begin
          w_state_nxt = S_IDLE;
        end else if (w_bad) begin
          w_state_nxt = S_ERR1;
        end else if (WAIT_STATES == 0) begin
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = 8'(WAIT_STATES);
        end
      end
    endcase
  end

  always_comb begin
    w_be = 4'b0000;
    case (r_size)
      2'd0:    w_be = 4'b0001 << r_lane;
      2'd1:    w_be = 4'b0011 << r_lane;
      default: w_be = 4'b1111;
    endcase
  end

  // Write commits on the edge closing DATA, so an overlapping read sees it.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == S_DATA) && r_hwrite) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[r_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_vscale_dmem_slave.sv
// Bench for vscale_dmem_slave: a transaction-level AHB master with a byte-lane
// memory model drives one instance with no wait states and one with three.
module tb_vscale_dmem_slave;

  logic        clk = 1'b0;
  logic        rst0, rst3;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic        hmastlock;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [31:0] hrdata0, hrdata3;
  logic        hready0, hready3;
  logic        hresp0, hresp3;

  always #5 clk = ~clk;

  vscale_dmem_slave #(.WAIT_STATES(0), .DEPTH_WORDS(1024)) u_dut0 (
    .clk(clk), .reset(rst0), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans),
    .hwdata(hwdata), .hrdata(hrdata0), .hready(hready0), .hresp(hresp0)
  );

  vscale_dmem_slave #(.WAIT_STATES(3), .DEPTH_WORDS(1024)) u_dut3 (
    .clk(clk), .reset(rst3), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans),
    .hwdata(hwdata), .hrdata(hrdata3), .hready(hready3), .hresp(hresp3)
  );

  typedef struct {
    bit          idle;
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [1:0]  trans;
  } txn_t;

  txn_t        q[$];
  txn_t        dp;
  bit          dp_valid, dp_bad;
  int          dp_cyc;
  int          sel, ws;
  bit [31:0]   mdl [int];
  int          n_tests, n_fail, lowcnt;
  logic [31:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_bad(input txn_t t);
    return (t.addr >= 32'd4096) || (t.size > 3'd2) ||
           ((t.size == 3'd1) && (t.addr % 2 != 0)) ||
           ((t.size == 3'd2) && (t.addr % 4 != 0));
  endfunction

  function automatic int key(input int s, input logic [31:0] a);
    return s * 1024 + int'(a[11:2]);
  endfunction

  task automatic mdl_write(input txn_t t);
    int        k, nb, lane;
    bit [31:0] w;
    k    = key(sel, t.addr);
    w    = mdl.exists(k) ? mdl[k] : 32'd0;
    nb   = 1 << t.size;
    lane = int'(t.addr % 4);
    for (int i = 0; i < nb; i++) w[8*(lane+i) +: 8] = t.wdata[8*(lane+i) +: 8];
    mdl[k] = w;
  endtask

  function automatic txn_t mk(input bit wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    txn_t t;
    t.idle = 1'b0; t.write = wr; t.addr = a; t.size = sz; t.wdata = d;
    t.trans = 2'($urandom_range(2, 3));
    return t;
  endfunction

  function automatic txn_t mk_idle();
    txn_t t;
    t.idle = 1'b1; t.write = 1'($urandom); t.addr = $urandom; t.size = 3'($urandom);
    t.wdata = $urandom; t.trans = 2'($urandom_range(0, 1));
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    int          r;
    logic [2:0]  sz;
    logic [31:0] a;
    r = int'($urandom_range(0, 99));
    if (r < 10) return mk_idle();
    if (r < 25) begin
      case ($urandom_range(0, 3))
        0: begin sz = 3'd2; a = 32'h1000 + 32'($urandom_range(0, 1023)) * 4; end
        1: begin sz = 3'($urandom_range(3, 7)); a = 32'($urandom_range(0, 255)); end
        2: begin sz = 3'd1; a = 32'($urandom_range(0, 127)) * 2 + 1; end
        default: begin sz = 3'd2; a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3)); end
      endcase
    end else begin
      sz = 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 255)) & ~((32'd1 << sz) - 32'd1);
    end
    return mk(1'($urandom), a, sz, $urandom);
  endfunction

  task automatic present(input txn_t t);
    haddr = t.addr; hwrite = t.write; hsize = t.size; htrans = t.trans;
    hburst = 3'($urandom); hmastlock = 1'($urandom); hprot = 4'($urandom);
  endtask

  // One bus cycle at the falling edge: check the current data phase, then
  // drive what the next rising edge samples and advance the model.
  task automatic cycle();
    bit          rdy_m, rsp_m;
    logic [31:0] rd_m, o_rd;
    logic        o_rdy, o_rsp;
    txn_t        t;
    o_rdy = sel ? hready3 : hready0;
    o_rsp = sel ? hresp3 : hresp0;
    o_rd  = sel ? hrdata3 : hrdata0;
    rd_m  = 32'd0;
    if (!dp_valid) begin
      rdy_m = 1'b1; rsp_m = 1'b0;
    end else if (dp_bad) begin
      rdy_m = (dp_cyc == 1); rsp_m = 1'b1;
    end else begin
      rdy_m = (dp_cyc == ws); rsp_m = 1'b0;
      if (rdy_m && !dp.write) rd_m = mdl[key(sel, dp.addr)];
    end
    chk("hready", 32'(o_rdy), 32'(rdy_m));
    chk("hresp", 32'(o_rsp), 32'(rsp_m));
    chk("hrdata", o_rd, rd_m);
    if (o_rdy !== 1'b1) lowcnt++;
    if (dp_valid && rdy_m && !dp_bad && !dp.write) last_rd = o_rd;
    hwdata = (dp_valid && dp.write) ? dp.wdata : $urandom;
    if (rdy_m) begin
      if (dp_valid && !dp_bad && dp.write) mdl_write(dp);
      dp_valid = 1'b0;
      t = (q.size() > 0) ? q.pop_front() : mk_idle();
      present(t);
      if (!t.idle) begin
        dp = t; dp_valid = 1'b1; dp_cyc = 0; dp_bad = is_bad(t);
      end
    end else begin
      dp_cyc++;
      present((q.size() > 0) ? q[0] : mk_idle());
    end
  endtask

  task automatic step();
    @(negedge clk);
    cycle();
  endtask

  task automatic run();
    int guard;
    guard = 0;
    while ((q.size() > 0 || dp_valid) && guard < 4000) begin
      step();
      guard++;
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 64; i++) q.push_back(mk(1'b1, 32'(i * 4), 3'd2, $urandom));
  endtask

  initial begin
    logic [31:0] w;
    n_tests = 0; n_fail = 0; lowcnt = 0; last_rd = 32'd0;
    dp_valid = 1'b0; dp_bad = 1'b0; dp_cyc = 0; sel = 0; ws = 0;
    rst0 = 1'b1; rst3 = 1'b1; hwdata = 32'd0;
    present(mk_idle());
    #12;
    chk("rst0_hready", 32'(hready0), 32'd1);
    chk("rst0_hresp", 32'(hresp0), 32'd0);
    chk("rst0_hrdata", hrdata0, 32'd0);
    chk("rst3_hready", 32'(hready3), 32'd1);

    // Zero-wait instance; first transfer sits on the bus as reset releases.
    preload();
    @(negedge clk);
    rst0 = 1'b0;
    cycle();
    run();

    lowcnt = 0;
    q.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF));
    q.push_back(mk(1'b0, 32'h10, 3'd2, 32'd0));
    run();
    chk("word_rd", last_rd, 32'hDEAD_BEEF);
    chk("word_nowait", 32'(lowcnt), 32'd0);

    q.push_back(mk(1'b1, 32'h30, 3'd2, 32'h5));
    q.push_back(mk(1'b0, 32'h30, 3'd2, 32'd0));
    run();
    chk("b2b_rd", last_rd, 32'h5);

    q.push_back(mk(1'b1, 32'h20, 3'd2, 32'h1122_3344));
    w = $urandom; w[15:8] = 8'hAA;
    q.push_back(mk(1'b1, 32'h21, 3'd0, w));
    w = $urandom; w[31:16] = 16'hBBCC;
    q.push_back(mk(1'b1, 32'h22, 3'd1, w));
    q.push_back(mk(1'b0, 32'h20, 3'd2, 32'd0));
    run();
    chk("subword_rd", last_rd, 32'hBBCC_AA44);

    lowcnt = 0;
    q.push_back(mk(1'b0, 32'h0, 3'd2, 32'd0));
    run();
    w = last_rd;
    q.push_back(mk(1'b1, 32'h1000, 3'd2, $urandom));
    q.push_back(mk(1'b0, 32'h02, 3'd2, 32'd0));
    q.push_back(mk(1'b0, 32'h0, 3'd2, 32'd0));
    run();
    chk("err_lowcnt", 32'(lowcnt), 32'd2);
    chk("err_mem_kept", last_rd, w);

    q.push_back(mk(1'b1, 32'hFFC, 3'd2, 32'hCAFE_F00D));
    q.push_back(mk(1'b1, 32'hFFF, 3'd0, 32'h5A00_0000));
    q.push_back(mk(1'b0, 32'h1000, 3'd0, 32'd0));
    q.push_back(mk(1'b0, 32'hFFC, 3'd2, 32'd0));
    run();
    chk("top_word_rd", last_rd, 32'h5AFE_F00D);

    repeat (250) q.push_back(rnd_txn());
    run();

    // Three-wait-state instance.
    @(negedge clk);
    rst0 = 1'b1; sel = 1; ws = 3;
    preload();
    @(negedge clk);
    rst3 = 1'b0;
    cycle();
    run();

    lowcnt = 0;
    q.push_back(mk(1'b0, 32'h8, 3'd2, 32'd0));
    q.push_back(mk(1'b0, 32'hC, 3'd2, 32'd0));
    run();
    chk("ws_lowcnt", 32'(lowcnt), 32'd6);
    chk("ws_rd", last_rd, mdl[key(1, 32'hC)]);

    repeat (60) q.push_back(rnd_txn());
    run();

    q.push_back(mk(1'b1, 32'h40, 3'd2, 32'h7));
    run();
    q.push_back(mk(1'b1, 32'h40, 3'd2, 32'h1234_5678));
    step();
    step();
    #2 rst3 = 1'b1;
    #1;
    chk("async_rst_hready", 32'(hready3), 32'd1);
    chk("async_rst_hresp", 32'(hresp3), 32'd0);
    chk("async_rst_hrdata", hrdata3, 32'd0);
    dp_valid = 1'b0;
    q.delete();
    present(mk_idle());
    @(negedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    q.push_back(mk(1'b0, 32'h40, 3'd2, 32'd0));
    cycle();
    run();
    chk("rst_drop_write", last_rd, 32'h7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
